llc_req_sequencer: RTL and testbench

//  Front-end controller for the LLC. Arbitrates between a CPU request port (ops 0,1,2,8,9) and a snoop port (ops 3-6).

---
 rtl/llc_req_sequencer_pkg.sv | 74 +++++++
 rtl/llc_req_sequencer_if.sv | 65 ++++++
 rtl/llc_req_sequencer_arbiter.sv | 42 ++++
 rtl/llc_req_sequencer.sv | 177 +++++++++++++++++
 tb/tb_llc_req_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/llc_req_sequencer_pkg.sv
// LLC request sequencer: shared op codes, LLC result enums,
// sequencer state and per-port op legality / replay decode.
package llc_req_sequencer_pkg;

  localparam logic [31:0] OP_RD       = 32'd0;
  localparam logic [31:0] OP_WR       = 32'd1;
  localparam logic [31:0] OP_IFETCH   = 32'd2;
  localparam logic [31:0] OP_SNP_RD   = 32'd3;
  localparam logic [31:0] OP_SNP_WR   = 32'd4;
  localparam logic [31:0] OP_SNP_RWIM = 32'd5;
  localparam logic [31:0] OP_SNP_INV  = 32'd6;
  localparam logic [31:0] OP_IDLE     = 32'd7;
  localparam logic [31:0] OP_CLR      = 32'd8;
  localparam logic [31:0] OP_PRINT    = 32'd9;

  typedef enum logic [2:0] {
    BUS_NONE   = 3'd0,
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RWIM       = 3'd4
  } busOperation;

  typedef enum logic [1:0] {
    NOHIT = 2'd0,
    HIT   = 2'd1,
    HITM  = 2'd2
  } snoopResults;

  typedef enum logic [2:0] {
    MSG_NONE       = 3'd0,
    GETLINE        = 3'd1,
    SENDLINE       = 3'd2,
    INVALIDATELINE = 3'd3,
    EVICTLINE      = 3'd4
  } messages;

  typedef enum logic [1:0] {
    IDLE, ISSUE, CHECK, RESP
  } seq_state_t;

  typedef enum logic {
    SRC_CPU, SRC_SNP
  } req_src_t;

  function automatic logic op_legal(
    input req_src_t    s,
    input logic [31:0] op
  );
    if (s == SRC_CPU)
      return op inside {OP_RD, OP_WR, OP_IFETCH,
                        OP_CLR, OP_PRINT};
    return op inside {OP_SNP_RD, OP_SNP_WR,
                      OP_SNP_RWIM, OP_SNP_INV};
  endfunction

  // An eviction/write-back hold forces the same op to be reissued.
  function automatic logic need_replay(
    input logic [31:0] op,
    input logic [31:0] hold,
    input messages     msg,
    input busOperation bo
  );
    logic h;
    h = (hold != '0);
    if (op inside {OP_RD, OP_WR, OP_IFETCH})
      return h && (msg == EVICTLINE ||
                   msg == INVALIDATELINE);
    if (op == OP_SNP_RWIM)
      return h && msg == GETLINE && bo == WRITE;
    return 1'b0;
  endfunction

endpackage

// File: rtl/llc_req_sequencer_if.sv
// Request, LLC-side and response signals of the sequencer.
// slave = sequencer, master = requesters/LLC/consumer.
interface llc_req_sequencer_if #(
  parameter int CNT_W = 32
);
  import llc_req_sequencer_pkg::*;

  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_op;
  logic [31:0] cpu_addr;

  logic        snp_valid;
  logic        snp_ready;
  logic [31:0] snp_op;
  logic [31:0] snp_addr;

  logic [31:0] llc_op;
  logic [31:0] llc_addr;
  busOperation llc_busop;
  snoopResults llc_snoop;
  messages     llc_msg;
  logic [31:0] llc_hold;

  logic        resp_valid;
  logic        resp_ready;
  req_src_t    resp_src;
  logic [31:0] resp_op;
  busOperation resp_busop;
  snoopResults resp_snoop;
  messages     resp_msg;
  logic [1:0]  resp_replays;
  logic        resp_err;

  logic [CNT_W-1:0] stat_cpu;
  logic [CNT_W-1:0] stat_snp;
  logic [CNT_W-1:0] stat_replay;

  modport slave (
    input  cpu_valid, cpu_op, cpu_addr,
    input  snp_valid, snp_op, snp_addr,
    input  llc_busop, llc_snoop, llc_msg,
    input  llc_hold, resp_ready,
    output cpu_ready, snp_ready,
    output llc_op, llc_addr,
    output resp_valid, resp_src, resp_op,
    output resp_busop, resp_snoop, resp_msg,
    output resp_replays, resp_err,
    output stat_cpu, stat_snp, stat_replay
  );

  modport master (
    output cpu_valid, cpu_op, cpu_addr,
    output snp_valid, snp_op, snp_addr,
    output llc_busop, llc_snoop, llc_msg,
    output llc_hold, resp_ready,
    input  cpu_ready, snp_ready,
    input  llc_op, llc_addr,
    input  resp_valid, resp_src, resp_op,
    input  resp_busop, resp_snoop, resp_msg,
    input  resp_replays, resp_err,
    input  stat_cpu, stat_snp, stat_replay
  );

endinterface

// File: rtl/llc_req_sequencer_arbiter.sv
// CPU/snoop priority arbiter: snoop first, CPU forced
// after STARVE_LIMIT snoop grants while CPU was waiting.
module llc_req_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpu_valid_i,
  input  logic       snp_valid_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          sat;
  logic          cpu_win;

  assign sat     = (starve_q == SW'(STARVE_LIMIT));
  assign cpu_win = cpu_valid_i && (!snp_valid_i || sat);
  assign gnt_o   = {snp_valid_i && !cpu_win, cpu_win};

  always_comb begin
    starve_d = starve_q;
    if (accept_i) begin
      unique case (1'b1)
        gnt_o[0]: starve_d = '0;
        gnt_o[1]: if (cpu_valid_i && !sat)
                    starve_d = starve_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

// File: rtl/llc_req_sequencer.sv
// LLC front-end: arbitrates CPU/snoop requests, issues one op
// at a time, replays on LLC hold and returns one response.
module llc_req_sequencer #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_REPLAY   = 2,
  parameter int CNT_W        = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  llc_req_sequencer_if.slave bus
);
  import llc_req_sequencer_pkg::*;

  seq_state_t       state_q;
  req_src_t         src_q;
  logic [31:0]      op_q;
  logic [1:0]       rcnt_q;
  logic [31:0]      llc_op_q;
  logic [31:0]      llc_addr_q;

  logic             rvalid_q;
  req_src_t         rsrc_q;
  logic [31:0]      rop_q;
  busOperation      rbusop_q;
  snoopResults      rsnoop_q;
  messages          rmsg_q;
  logic [1:0]       rrep_q;
  logic             rerr_q;

  logic [CNT_W-1:0] st_cpu_q;
  logic [CNT_W-1:0] st_snp_q;
  logic [CNT_W-1:0] st_rep_q;

  logic [1:0]       gnt;
  logic             free;
  logic             acc_cpu;
  logic             acc_snp;
  logic             accept;
  req_src_t         acc_src;
  logic [31:0]      acc_op;
  logic [31:0]      acc_addr;
  logic             replay;
  logic             can_replay;

  llc_req_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_valid_i (bus.cpu_valid),
    .snp_valid_i (bus.snp_valid),
    .accept_i    (accept),
    .gnt_o       (gnt)
  );

  assign free = (state_q == IDLE) && !rvalid_q
             && !rst_i;
  assign bus.cpu_ready = free && gnt[0];
  assign bus.snp_ready = free && gnt[1];
  assign acc_cpu = bus.cpu_valid && bus.cpu_ready;
  assign acc_snp = bus.snp_valid && bus.snp_ready;
  assign accept  = acc_cpu || acc_snp;

  always_comb begin
    acc_src  = SRC_CPU;
    acc_op   = bus.cpu_op;
    acc_addr = bus.cpu_addr;
    unique case (1'b1)
      acc_snp: begin
        acc_src  = SRC_SNP;
        acc_op   = bus.snp_op;
        acc_addr = bus.snp_addr;
      end
      default: ;
    endcase
  end

  assign replay = need_replay(op_q, bus.llc_hold,
                              bus.llc_msg,
                              bus.llc_busop);
  assign can_replay = rcnt_q < 2'(MAX_REPLAY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      src_q      <= SRC_CPU;
      op_q       <= '0;
      rcnt_q     <= '0;
      llc_op_q   <= OP_IDLE;
      llc_addr_q <= '0;
      rvalid_q   <= 1'b0;
      rsrc_q     <= SRC_CPU;
      rop_q      <= '0;
      rbusop_q   <= BUS_NONE;
      rsnoop_q   <= NOHIT;
      rmsg_q     <= MSG_NONE;
      rrep_q     <= '0;
      rerr_q     <= 1'b0;
      st_cpu_q   <= '0;
      st_snp_q   <= '0;
      st_rep_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          src_q  <= acc_src;
          op_q   <= acc_op;
          rcnt_q <= '0;
          if (acc_cpu) st_cpu_q <= st_cpu_q + 1'b1;
          if (acc_snp) st_snp_q <= st_snp_q + 1'b1;
          if (op_legal(acc_src, acc_op)) begin
            llc_op_q   <= acc_op;
            llc_addr_q <= acc_addr;
            state_q    <= ISSUE;
          end else begin
            // rejected op never reaches the LLC
            rvalid_q <= 1'b1;
            rsrc_q   <= acc_src;
            rop_q    <= acc_op;
            rbusop_q <= BUS_NONE;
            rsnoop_q <= NOHIT;
            rmsg_q   <= MSG_NONE;
            rrep_q   <= '0;
            rerr_q   <= 1'b1;
            state_q  <= RESP;
          end
        end
        ISSUE: begin
          llc_op_q <= OP_IDLE;
          state_q  <= CHECK;
        end
        CHECK: begin
          if (replay && can_replay) begin
            llc_op_q <= op_q;
            rcnt_q   <= rcnt_q + 1'b1;
            st_rep_q <= st_rep_q + 1'b1;
            state_q  <= ISSUE;
          end else begin
            rvalid_q <= 1'b1;
            rsrc_q   <= src_q;
            rop_q    <= op_q;
            rbusop_q <= bus.llc_busop;
            rsnoop_q <= bus.llc_snoop;
            rmsg_q   <= bus.llc_msg;
            rrep_q   <= rcnt_q;
            rerr_q   <= replay;
            state_q  <= RESP;
            if (op_q == OP_CLR) begin
              st_cpu_q <= '0;
              st_snp_q <= '0;
              st_rep_q <= '0;
            end
          end
        end
        RESP: if (bus.resp_ready) begin
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.llc_op       = llc_op_q;
  assign bus.llc_addr     = llc_addr_q;
  assign bus.resp_valid   = rvalid_q;
  assign bus.resp_src     = rsrc_q;
  assign bus.resp_op      = rop_q;
  assign bus.resp_busop   = rbusop_q;
  assign bus.resp_snoop   = rsnoop_q;
  assign bus.resp_msg     = rmsg_q;
  assign bus.resp_replays = rrep_q;
  assign bus.resp_err     = rerr_q;
  assign bus.stat_cpu     = st_cpu_q;
  assign bus.stat_snp     = st_snp_q;
  assign bus.stat_replay  = st_rep_q;

endmodule

// File: tb/tb_llc_req_sequencer.sv
// Directed bench for llc_req_sequencer; the bench plays
// the LLC by driving its result signals per vector.
module tb_llc_req_sequencer;
  import llc_req_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  llc_req_sequencer_if #(.CNT_W(32)) bus ();

  llc_req_sequencer #(
    .STARVE_LIMIT(4),
    .MAX_REPLAY  (2),
    .CNT_W       (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic llc_set(input busOperation b,
                         input snoopResults s,
                         input messages m,
                         input logic [31:0] h);
    bus.llc_busop = b;
    bus.llc_snoop = s;
    bus.llc_msg   = m;
    bus.llc_hold  = h;
  endtask

  // returns one step after the accepting edge
  task automatic send(input bit s,
                      input logic [31:0] op,
                      input logic [31:0] a);
    int n;
    if (s) begin
      bus.snp_valid = 1'b1;
      bus.snp_op    = op;
      bus.snp_addr  = a;
    end else begin
      bus.cpu_valid = 1'b1;
      bus.cpu_op    = op;
      bus.cpu_addr  = a;
    end
    #1;
    n = 0;
    while (!(s ? bus.snp_ready : bus.cpu_ready)
           && n < 20) begin
      tick;
      n++;
    end
    if (n >= 20) chk("send_timeout", 64'(n), 0);
    tick;
    bus.cpu_valid = 1'b0;
    bus.snp_valid = 1'b0;
  endtask

  task automatic consume;
    bus.resp_ready = 1'b1;
    tick;
    bus.resp_ready = 1'b0;
    chk("rsp_drop", 64'(bus.resp_valid), 0);
  endtask

  initial begin
    int g;
    int cyc;
    int n;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.cpu_valid  = 1'b1;
    bus.cpu_op     = OP_RD;
    bus.cpu_addr   = 32'h0;
    bus.snp_valid  = 1'b0;
    bus.snp_op     = OP_SNP_RD;
    bus.snp_addr   = 32'h0;
    bus.resp_ready = 1'b0;
    llc_set(READ, NOHIT, SENDLINE, 0);
    tick;
    tick;
    chk("rst_llc_op", 64'(bus.llc_op), 7);
    chk("rst_llc_addr", 64'(bus.llc_addr), 0);
    chk("rst_cpu_rdy", 64'(bus.cpu_ready), 0);
    chk("rst_rvalid", 64'(bus.resp_valid), 0);
    chk("rst_stat", 64'(bus.stat_cpu), 0);
    bus.cpu_valid = 1'b0;
    rst = 1'b0;
    tick;

    // plain CPU read
    send(0, OP_RD, 32'h1000);
    chk("t1_op_e0", 64'(bus.llc_op), 0);
    chk("t1_addr", 64'(bus.llc_addr), 32'h1000);
    tick;
    chk("t1_op_e1", 64'(bus.llc_op), 7);
    chk("t1_nv_e1", 64'(bus.resp_valid), 0);
    tick;
    chk("t1_rv", 64'(bus.resp_valid), 1);
    chk("t1_bus", 64'(bus.resp_busop), 64'(READ));
    chk("t1_msg", 64'(bus.resp_msg), 64'(SENDLINE));
    chk("t1_rep", 64'(bus.resp_replays), 0);
    chk("t1_err", 64'(bus.resp_err), 0);
    chk("t1_src", 64'(bus.resp_src), 0);
    consume;
    chk("t1_stc", 64'(bus.stat_cpu), 1);

    // eviction hold on first pass, one reissue
    send(0, OP_RD, 32'h2040);
    llc_set(READ, NOHIT, EVICTLINE, 1);
    tick;
    tick;
    chk("t2_reissue", 64'(bus.llc_op), 0);
    chk("t2_nv", 64'(bus.resp_valid), 0);
    llc_set(READ, NOHIT, SENDLINE, 1);
    tick;
    chk("t2_op_idle", 64'(bus.llc_op), 7);
    tick;
    chk("t2_rv", 64'(bus.resp_valid), 1);
    chk("t2_bus", 64'(bus.resp_busop), 64'(READ));
    chk("t2_rep", 64'(bus.resp_replays), 1);
    chk("t2_err", 64'(bus.resp_err), 0);
    chk("t2_str", 64'(bus.stat_replay), 1);
    consume;

    // snoop RWIM replay on GETLINE/WRITE
    send(1, OP_SNP_RWIM, 32'h1000);
    llc_set(WRITE, HIT, GETLINE, 1);
    tick;
    tick;
    chk("t3_reissue", 64'(bus.llc_op), 5);
    llc_set(INVALIDATE, HIT, INVALIDATELINE, 1);
    tick;
    tick;
    chk("t3_rv", 64'(bus.resp_valid), 1);
    chk("t3_src", 64'(bus.resp_src), 1);
    chk("t3_op", 64'(bus.resp_op), 5);
    chk("t3_bus", 64'(bus.resp_busop),
        64'(INVALIDATE));
    chk("t3_msg", 64'(bus.resp_msg),
        64'(INVALIDATELINE));
    chk("t3_snp", 64'(bus.resp_snoop), 64'(HIT));
    chk("t3_rep", 64'(bus.resp_replays), 1);
    chk("t3_str", 64'(bus.stat_replay), 2);
    consume;

    // permanent hold: two reissues then error
    send(0, OP_WR, 32'h3000);
    llc_set(WRITE, NOHIT, EVICTLINE, 1);
    for (int i = 0; i < 5; i++) tick;
    chk("t4_nv", 64'(bus.resp_valid), 0);
    tick;
    chk("t4_rv", 64'(bus.resp_valid), 1);
    chk("t4_err", 64'(bus.resp_err), 1);
    chk("t4_rep", 64'(bus.resp_replays), 2);
    chk("t4_op", 64'(bus.resp_op), 1);
    chk("t4_str", 64'(bus.stat_replay), 4);
    consume;
    llc_set(READ, NOHIT, SENDLINE, 0);

    // illegal ops on each port
    send(0, OP_SNP_RD, 32'h4000);
    chk("t5_rv", 64'(bus.resp_valid), 1);
    chk("t5_err", 64'(bus.resp_err), 1);
    chk("t5_llc", 64'(bus.llc_op), 7);
    consume;
    send(1, OP_WR, 32'h4000);
    chk("t5s_err", 64'(bus.resp_err), 1);
    chk("t5s_src", 64'(bus.resp_src), 1);
    chk("t5s_llc", 64'(bus.llc_op), 7);
    consume;
    chk("t5_stc", 64'(bus.stat_cpu), 4);
    chk("t5_sts", 64'(bus.stat_snp), 2);

    // clear op wipes statistics
    send(0, OP_CLR, 32'h0);
    chk("t6_stc_acc", 64'(bus.stat_cpu), 5);
    tick;
    tick;
    chk("t6_rv", 64'(bus.resp_valid), 1);
    chk("t6_stc", 64'(bus.stat_cpu), 0);
    chk("t6_sts", 64'(bus.stat_snp), 0);
    chk("t6_str", 64'(bus.stat_replay), 0);
    consume;

    // both ports saturated: 4 snoops then 1 CPU
    bus.cpu_valid  = 1'b1;
    bus.cpu_op     = OP_RD;
    bus.cpu_addr   = 32'h5000;
    bus.snp_valid  = 1'b1;
    bus.snp_op     = OP_SNP_RD;
    bus.snp_addr   = 32'h6000;
    bus.resp_ready = 1'b1;
    #1;
    g   = 0;
    cyc = 0;
    while (g < 10 && cyc < 200) begin
      if (bus.snp_valid && bus.snp_ready) begin
        chk($sformatf("t7_g%0d", g), 1,
            64'(g % 5 != 4));
        g++;
      end else if (bus.cpu_valid &&
                   bus.cpu_ready) begin
        chk($sformatf("t7_g%0d", g), 0,
            64'(g % 5 != 4));
        g++;
      end
      tick;
      cyc++;
    end
    if (g < 10) chk("t7_timeout", 64'(g), 10);
    bus.cpu_valid = 1'b0;
    bus.snp_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    bus.resp_ready = 1'b0;
    chk("t7_stc", 64'(bus.stat_cpu), 2);
    chk("t7_sts", 64'(bus.stat_snp), 8);

    // reset while in CHECK drops the request
    send(0, OP_RD, 32'h7000);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t8_rv", 64'(bus.resp_valid), 0);
    chk("t8_llc", 64'(bus.llc_op), 7);
    chk("t8_stc", 64'(bus.stat_cpu), 0);
    for (int i = 0; i < 3; i++) tick;
    chk("t8_rv_late", 64'(bus.resp_valid), 0);

    send(0, OP_IFETCH, 32'h8000);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      tick;
      n++;
    end
    chk("t9_lat", 64'(n), 2);
    chk("t9_op", 64'(bus.resp_op), 2);
    chk("t9_rep", 64'(bus.resp_replays), 0);
    chk("t9_err", 64'(bus.resp_err), 0);
    chk("t9_stc", 64'(bus.stat_cpu), 1);
    consume;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
